// File: rtl/ysyx_23060184_axi_arbiter.sv
// Two-way arbiter for the shared SoC AXI4 master port (IFU fetch vs. LSU).
// A grant is held until the owner's transaction completes (snooped R or B
// handshake), the owner aborts before its address phase, or the watchdog
// expires. Every grant is followed by one RELEASE cycle with both grants low
// so the SoCMem idle/valid registers settle before the next owner is chosen.
module ysyx_23060184_axi_arbiter #(
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_WIDTH      = 16
) (
    input  logic clock,
    input  logic rst_n,
    input  logic ifu_req,
    input  logic lsu_req,
    input  logic lsu_is_write,
    input  logic arvalid,
    input  logic arready,
    input  logic awvalid,
    input  logic awready,
    input  logic rvalid,
    input  logic rready,
    input  logic bvalid,
    input  logic bready,
    output logic ifu_grant,
    output logic lsu_grant,
    output logic bus_sel,
    output logic busy,
    output logic timeout_err,
    output logic last_owner
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_IFU = 2'd1,
        GRANT_LSU = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    // Watchdog terminal count; the grant is reclaimed in the cycle it is reached.
    localparam logic [CNT_WIDTH-1:0] WDOG_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state;
    logic                 is_wr;
    logic                 addr_done;
    logic [CNT_WIDTH-1:0] wdog;

    logic owner_req;
    logic addr_hs;
    logic done_hs;
    logic expire;
    logic abort;
    logic pick_lsu;

    // Decode snooped handshakes against the type of the transaction in flight
    always_comb begin
        owner_req = (state == GRANT_LSU) ? lsu_req : ifu_req;
        addr_hs   = is_wr ? (awvalid & awready) : (arvalid & arready);
        done_hs   = is_wr ? (bvalid & bready) : (rvalid & rready);
        expire    = (wdog == WDOG_LAST);
        // Dropping req is only a legal abort before the address went out.
        abort     = !owner_req && !addr_done;
        if (FIXED_PRIO != 0) begin
            pick_lsu = lsu_req;
        end else begin
            // Round-robin: on a tie the unit that did not own the bus last wins.
            pick_lsu = lsu_req && (!ifu_req || !last_owner);
        end
    end

    // Arbitration FSM with all outputs registered
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ifu_grant   <= 1'b0;
            lsu_grant   <= 1'b0;
            bus_sel     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            last_owner  <= 1'b1;
            is_wr       <= 1'b0;
            addr_done   <= 1'b0;
            wdog        <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ifu_req || lsu_req) begin
                        wdog      <= '0;
                        addr_done <= 1'b0;
                        busy      <= 1'b1;
                        if (pick_lsu) begin
                            state     <= GRANT_LSU;
                            lsu_grant <= 1'b1;
                            bus_sel   <= 1'b1;
                            is_wr     <= lsu_is_write;
                        end else begin
                            state     <= GRANT_IFU;
                            ifu_grant <= 1'b1;
                            bus_sel   <= 1'b0;
                            is_wr     <= 1'b0;
                        end
                    end
                end
                GRANT_IFU, GRANT_LSU: begin
                    if (done_hs || abort || expire) begin
                        state       <= RELEASE;
                        ifu_grant   <= 1'b0;
                        lsu_grant   <= 1'b0;
                        last_owner  <= (state == GRANT_LSU);
                        // A completion or abort in the expiry cycle wins over the error.
                        timeout_err <= expire && !done_hs && !abort;
                    end else begin
                        wdog <= wdog + 1'b1;
                        if (addr_hs) begin
                            addr_done <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Mutual exclusion of the two grants
    a_one_hot_grant: assert property (@(posedge clock) disable iff (!rst_n)
        !(ifu_grant && lsu_grant));

endmodule

// File: tb/tb_ysyx_23060184_axi_arbiter.sv
// Bench for the IFU/LSU AXI arbiter. Two instances share all inputs: one
// round-robin, one fixed-priority, both with an 8-cycle watchdog.
module tb_ysyx_23060184_axi_arbiter;

    localparam int TMO = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_n;
    logic ifu_req, lsu_req, lsu_is_write;
    logic arvalid, arready, awvalid, awready;
    logic rvalid, rready, bvalid, bready;

    logic ig_rr, lg_rr, sel_rr, busy_rr, terr_rr, last_rr;
    logic ig_fp, lg_fp, sel_fp, busy_fp, terr_fp, last_fp;

    int total = 0;
    int bad   = 0;

    ysyx_23060184_axi_arbiter #(
        .FIXED_PRIO(0), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(16)
    ) dut_rr (
        .clock(clock), .rst_n(rst_n),
        .ifu_req(ifu_req), .lsu_req(lsu_req), .lsu_is_write(lsu_is_write),
        .arvalid(arvalid), .arready(arready), .awvalid(awvalid), .awready(awready),
        .rvalid(rvalid), .rready(rready), .bvalid(bvalid), .bready(bready),
        .ifu_grant(ig_rr), .lsu_grant(lg_rr), .bus_sel(sel_rr), .busy(busy_rr),
        .timeout_err(terr_rr), .last_owner(last_rr)
    );

    ysyx_23060184_axi_arbiter #(
        .FIXED_PRIO(1), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(16)
    ) dut_fp (
        .clock(clock), .rst_n(rst_n),
        .ifu_req(ifu_req), .lsu_req(lsu_req), .lsu_is_write(lsu_is_write),
        .arvalid(arvalid), .arready(arready), .awvalid(awvalid), .awready(awready),
        .rvalid(rvalid), .rready(rready), .bvalid(bvalid), .bready(bready),
        .ifu_grant(ig_fp), .lsu_grant(lg_fp), .bus_sel(sel_fp), .busy(busy_fp),
        .timeout_err(terr_fp), .last_owner(last_fp)
    );

    // Reference model: index 0 = round-robin, 1 = fixed priority.
    // owner: 0 none, 1 IFU, 2 LSU; rel marks the one-cycle gap after a grant.
    int m_owner[2];
    int m_age[2];
    bit m_rel[2], m_wr[2], m_adone[2], m_last[2], m_sel[2], m_terr[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = 0; m_age[m] = 0; m_rel[m] = 0; m_wr[m] = 0;
            m_adone[m] = 0; m_last[m] = 1; m_sel[m] = 0; m_terr[m] = 0;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step(input int m);
        bit take_lsu, req, ahs, dhs, expired, aborted;
        m_terr[m] = 0;
        if (m_rel[m]) begin
            m_rel[m] = 0;
        end else if (m_owner[m] == 0) begin
            if (ifu_req || lsu_req) begin
                if (m == 1) take_lsu = lsu_req;
                else        take_lsu = lsu_req && (!ifu_req || !m_last[m]);
                m_owner[m] = take_lsu ? 2 : 1;
                m_sel[m]   = take_lsu;
                m_wr[m]    = take_lsu ? lsu_is_write : 1'b0;
                m_age[m]   = 0;
                m_adone[m] = 0;
            end
        end else begin
            req     = (m_owner[m] == 2) ? lsu_req : ifu_req;
            ahs     = m_wr[m] ? (awvalid && awready) : (arvalid && arready);
            dhs     = m_wr[m] ? (bvalid && bready) : (rvalid && rready);
            expired = (m_age[m] + 1 >= TMO);
            aborted = !req && !m_adone[m];
            if (dhs || aborted || expired) begin
                m_terr[m]  = expired && !dhs && !aborted;
                m_last[m]  = (m_owner[m] == 2);
                m_owner[m] = 0;
                m_rel[m]   = 1;
            end else begin
                m_age[m] = m_age[m] + 1;
                if (ahs) m_adone[m] = 1;
            end
        end
    endtask

    task automatic set_idle();
        ifu_req = 0; lsu_req = 0; lsu_is_write = 0;
        arvalid = 0; arready = 0; awvalid = 0; awready = 0;
        rvalid = 0; rready = 0; bvalid = 0; bready = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        set_idle();
        @(posedge clock);
        @(posedge clock);
        #1 rst_n = 1;
    endtask

    // One clock: outputs are sampled 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({ig_rr, lg_rr, sel_rr, busy_rr, terr_rr, last_rr} !== 6'b000001) begin
            bad++;
            $display("FAIL reset_rr got=%b want=000001", {ig_rr, lg_rr, sel_rr, busy_rr, terr_rr, last_rr});
        end
        total++;
        if ({ig_fp, lg_fp, sel_fp, busy_fp, terr_fp, last_fp} !== 6'b000001) begin
            bad++;
            $display("FAIL reset_fp got=%b want=000001", {ig_fp, lg_fp, sel_fp, busy_fp, terr_fp, last_fp});
        end
    endtask

    task automatic test_ifu_only();
        do_reset();
        ifu_req = 1;
        cycle();
        total++;
        if ({ig_rr, lg_rr, sel_rr, busy_rr} !== 4'b1001) begin
            bad++;
            $display("FAIL ifu_only_grant got=%b want=1001", {ig_rr, lg_rr, sel_rr, busy_rr});
        end
        total++;
        if ({ig_fp, lg_fp} !== 2'b10) begin
            bad++;
            $display("FAIL ifu_only_grant_fp got=%b want=10", {ig_fp, lg_fp});
        end
        for (int c = 1; c < 6; c++) begin
            arvalid = (c == 3);
            arready = (c == 3);
            cycle();
            total++;
            if (ig_rr !== 1'b1) begin
                bad++;
                $display("FAIL ifu_only_hold cyc=%0d got=%b want=1", c + 1, ig_rr);
            end
        end
        arvalid = 0; arready = 0;
        rvalid = 1; rready = 1;
        cycle();
        total++;
        if ({ig_rr, lg_rr, busy_rr, last_rr} !== 4'b0010) begin
            bad++;
            $display("FAIL ifu_only_release got=%b want=0010", {ig_rr, lg_rr, busy_rr, last_rr});
        end
        rvalid = 0; rready = 0; ifu_req = 0;
        cycle();
        total++;
        if ({ig_rr, busy_rr} !== 2'b00) begin
            bad++;
            $display("FAIL ifu_only_idle got=%b want=00", {ig_rr, busy_rr});
        end
    endtask

    task automatic test_priority();
        logic [1:0] want_rr;
        do_reset();
        ifu_req = 1; lsu_req = 1; lsu_is_write = 0;
        for (int r = 0; r < 3; r++) begin
            cycle();
            want_rr = (r == 1) ? 2'b01 : 2'b10;
            total++;
            if ({ig_rr, lg_rr} !== want_rr) begin
                bad++;
                $display("FAIL tie_rr round=%0d got=%b want=%b", r, {ig_rr, lg_rr}, want_rr);
            end
            total++;
            if ({ig_fp, lg_fp} !== 2'b01) begin
                bad++;
                $display("FAIL tie_fp round=%0d got=%b want=01", r, {ig_fp, lg_fp});
            end
            rvalid = 1; rready = 1;
            cycle();
            total++;
            if ({ig_rr, lg_rr, busy_rr, ig_fp, lg_fp, busy_fp} !== 6'b001001) begin
                bad++;
                $display("FAIL tie_release round=%0d got=%b want=001001", r,
                         {ig_rr, lg_rr, busy_rr, ig_fp, lg_fp, busy_fp});
            end
            rvalid = 0; rready = 0;
            cycle();
            total++;
            if ({busy_rr, busy_fp} !== 2'b00) begin
                bad++;
                $display("FAIL tie_idle round=%0d got=%b want=00", r, {busy_rr, busy_fp});
            end
        end
    endtask

    task automatic test_store();
        do_reset();
        lsu_req = 1; lsu_is_write = 1;
        cycle();
        total++;
        if ({lg_rr, sel_rr} !== 2'b11) begin
            bad++;
            $display("FAIL store_grant got=%b want=11", {lg_rr, sel_rr});
        end
        rvalid = 1; rready = 1;
        cycle();
        rvalid = 0; rready = 0;
        total++;
        if ({lg_rr, lg_fp} !== 2'b11) begin
            bad++;
            $display("FAIL store_stray_r got=%b want=11", {lg_rr, lg_fp});
        end
        awvalid = 1; awready = 1;
        cycle();
        awvalid = 0; awready = 0;
        total++;
        if (lg_rr !== 1'b1) begin
            bad++;
            $display("FAIL store_aw got=%b want=1", lg_rr);
        end
        cycle();
        total++;
        if (lg_rr !== 1'b1) begin
            bad++;
            $display("FAIL store_w got=%b want=1", lg_rr);
        end
        bvalid = 1; bready = 1;
        cycle();
        total++;
        if ({lg_rr, sel_rr, busy_rr, last_rr} !== 4'b0111) begin
            bad++;
            $display("FAIL store_b got=%b want=0111", {lg_rr, sel_rr, busy_rr, last_rr});
        end
        set_idle();
        cycle();
        total++;
        if ({busy_rr, sel_rr} !== 2'b01) begin
            bad++;
            $display("FAIL store_idle_sel got=%b want=01", {busy_rr, sel_rr});
        end
    endtask

    task automatic test_timeout();
        int pulses;
        int t;
        do_reset();
        pulses = 0;
        for (int c = 0; c < 11; c++) begin
            ifu_req = 1;
            lsu_req = (c >= 1);
            cycle();
            t = c + 1;
            if (terr_rr === 1'b1) pulses++;
            total++;
            if (terr_rr !== (t == 9)) begin
                bad++;
                $display("FAIL timeout_err cyc=%0d got=%b want=%b", t, terr_rr, (t == 9));
            end
            total++;
            if (ig_rr !== (t >= 1 && t <= 8)) begin
                bad++;
                $display("FAIL timeout_ifu_grant cyc=%0d got=%b want=%b", t, ig_rr, (t >= 1 && t <= 8));
            end
            total++;
            if (lg_rr !== (t == 11)) begin
                bad++;
                $display("FAIL timeout_lsu_grant cyc=%0d got=%b want=%b", t, lg_rr, (t == 11));
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL timeout_pulse_count got=%0d want=1", pulses);
        end
        set_idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        ifu_req = 1;
        cycle();
        total++;
        if (ig_rr !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre got=%b want=1", ig_rr);
        end
        rst_n = 0;
        #1;
        total++;
        if ({ig_rr, lg_rr, busy_rr, ig_fp, lg_fp, busy_fp} !== 6'b000000) begin
            bad++;
            $display("FAIL areset_drop got=%b want=000000", {ig_rr, lg_rr, busy_rr, ig_fp, lg_fp, busy_fp});
        end
        lsu_req = 1;
        #3 rst_n = 1;
        cycle();
        total++;
        if ({ig_rr, lg_rr} !== 2'b10) begin
            bad++;
            $display("FAIL areset_tie_rr got=%b want=10", {ig_rr, lg_rr});
        end
        total++;
        if ({ig_fp, lg_fp} !== 2'b01) begin
            bad++;
            $display("FAIL areset_tie_fp got=%b want=01", {ig_fp, lg_fp});
        end
        set_idle();
    endtask

    task automatic test_random();
        logic [5:0] got, want;
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            ifu_req      = ($urandom_range(0, 3) != 0);
            lsu_req      = ($urandom_range(0, 3) != 0);
            lsu_is_write = $urandom_range(0, 1);
            arvalid = ($urandom_range(0, 2) == 0); arready = ($urandom_range(0, 1) == 0);
            awvalid = ($urandom_range(0, 2) == 0); awready = ($urandom_range(0, 1) == 0);
            rvalid  = ($urandom_range(0, 3) == 0); rready  = ($urandom_range(0, 1) == 0);
            bvalid  = ($urandom_range(0, 3) == 0); bready  = ($urandom_range(0, 1) == 0);
            model_step(0);
            model_step(1);
            cycle();
            for (int m = 0; m < 2; m++) begin
                want = {m_owner[m] == 1, m_owner[m] == 2, m_sel[m],
                        (m_owner[m] != 0) || m_rel[m], m_terr[m], m_last[m]};
                got  = (m == 0) ? {ig_rr, lg_rr, sel_rr, busy_rr, terr_rr, last_rr}
                                : {ig_fp, lg_fp, sel_fp, busy_fp, terr_fp, last_fp};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL random inst=%0d cyc=%0d got=%b want=%b", m, c, got, want);
                end
            end
        end
        set_idle();
    endtask

    initial begin
        rst_n = 0;
        set_idle();
        model_reset();
        test_reset();
        test_ifu_only();
        test_priority();
        test_store();
        test_timeout();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
